muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit directly downstream of the register file.
- Consumes the two read-data values as operands, computes the 32-bit result over multiple cycles, and hands it to writeback.
- Exposes a start/busy/done handshake so the pipeline can stall while an operation runs.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only while busy=0
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (multiplicand/dividend)
op_b  input  XLEN  rs2 value (multiplier/divisor)
kill  input  1  abort the in-flight operation (pipeline flush)
busy  output  1  high from the cycle after start is accepted until the cycle after done
done  output  1  one-cycle pulse; result valid in that cycle
result  output  XLEN  operation result; holds its value until the next done

Behaviour:
- Reset: rst=1 at a rising edge forces state IDLE, busy=0, done=0, result=0, counter=0, internal operand registers=0. This applies mid-operation and takes priority over kill and start.
- States: IDLE, CALC, DONE. busy = (state != IDLE).
- IDLE with start=1 at edge T: latch funct3, op_a, op_b, and operand signs into internal registers.
  - Signed operands are converted to magnitudes. MULH and DIV/REM treat both operands as signed; MULHSU treats only op_a as signed.
  - Fast path: divide ops with op_b=0 go to DONE, so done=1 in cycle T+1.
  - All other ops go to CALC with counter=XLEN.
- CALC: one radix-2 iteration per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract into quotient/remainder registers.
  - The counter decrements each cycle. After XLEN iterations, go to DONE.
- Normal latency: start accepted at edge T, CALC occupies cycles T+1..T+XLEN, and done=1 in cycle T+XLEN+1 (T+33 for XLEN=32).
- DONE: done=1 and result valid for exactly one cycle, then IDLE. busy returns to 0 in the following cycle. result stays stable until the next done.
- Sign fix-up, applied when entering DONE:
  - Product: negated as a 2*XLEN two's-complement value if the operand signs differ.
  - Quotient: negated if the signs differ and the divisor is nonzero.
  - Remainder: takes the sign of the dividend.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Divide by zero (RISC-V rules): quotient = all ones (0xFFFFFFFF) for both DIV and DIVU; remainder = op_a unchanged.
- Signed overflow: op_a=0x80000000 with op_b=0xFFFFFFFF on DIV gives 0x80000000; on REM gives 0. This falls out of magnitude arithmetic plus sign fix-up. No special path is required, but the result is mandatory.
- start while busy=1, including in the DONE cycle, is ignored. Operands are not re-latched.
- kill=1 in CALC or DONE: next state is IDLE, done is suppressed, result keeps its previous value. kill in IDLE has no effect.
- kill and start asserted together in IDLE: start wins.
- Inputs op_a, op_b, and funct3 may change freely after acceptance. Only the latched copies are used.

Test Plan:
- MUL op_a=7, op_b=6, start at T -> busy=1 from T+1; done=1 and result=42 (0x2A) only at T+33; busy=0 at T+34.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000.
  - Same operands, MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
  - MUL -> 0x00000001.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD (-3).
  - REM -> 0xFFFFFFFF (-1).
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- DIVU 5/0 -> done at T+1, result 0xFFFFFFFF.
  - REM 5/0 -> done at T+1, result 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Start MUL 3×4 at T, kill at T+10 -> no done pulse, busy=0 at T+12, result unchanged. New start at T+12 -> correct result at T+45.
- Start at T, second start with different operands at T+5, and rst=1 at T+20 -> second start ignored; after reset busy=0, done=0, result=0, no done pulse follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Accepts one operation per start handshake. Multiplies use radix-2
// shift-add over signed-magnitude operands. Divides use radix-2 restoring
// shift-subtract. The sign fix-up is applied as the result is registered.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request a new operation (sampled only while idle)
//   funct3        RV32M operation select (MUL..REMU)
//   op_a, op_b    rs1 / rs2 operand values
//   kill          abort the in-flight operation
//   busy          unit is occupied (state != IDLE)
//   done          one-cycle result-valid pulse
//   result        last completed result, held until the next done
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one radix-2 iteration per cycle, count runs XLEN down to 1
// DONE  | done/result presented for one cycle
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      f3_q;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] opnd;
  // Shared datapath register: {product high, multiplier} for multiplies,
  // {partial remainder, dividend/quotient} for divides.
  logic [2*XLEN-1:0] acc;

  logic            sgn_a_in;
  logic            sgn_b_in;
  logic            neg_a_in;
  logic            neg_b_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;
  logic            div_by_zero;

  always_comb begin
    sgn_a_in    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b_in    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a_in    = sgn_a_in & op_a[XLEN-1];
    neg_b_in    = sgn_b_in & op_b[XLEN-1];
    mag_a_in    = neg_a_in ? -op_a : op_a;
    mag_b_in    = neg_b_in ? -op_b : op_b;
    div_by_zero = funct3[2] && (op_b == '0);
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_fix;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_next  = {mul_sum, acc[XLEN-1:1]};
    if (f3_q[2]) begin
      // Restoring step: keep the shifted remainder when the trial subtract borrows.
      if (div_diff[XLEN])
        acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
    // Divisor is never zero here; zero divisors bypass CALC entirely.
    prod = (neg_a ^ neg_b) ? -acc_next : acc_next;
    quo  = (neg_a ^ neg_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = neg_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 res_fix = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fix = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_fix = quo;
      default:                res_fix = rem;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      f3_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            f3_q  <= funct3;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            opnd  <= mag_b_in;
            acc   <= {{XLEN{1'b0}}, mag_a_in};
            if (div_by_zero) begin
              // Quotient is all ones; remainder is the untouched dividend.
              state  <= DONE;
              count  <= '0;
              done   <= 1'b1;
              result <= funct3[1] ? op_a : '1;
            end else begin
              state <= CALC;
              count <= CW'(XLEN);
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
            count <= '0;
          end else begin
            acc   <= acc_next;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= res_fix;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic and RISC-V corner-case rules.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic signed [31:0] ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'h0, a};
    zb = {32'h0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to completion. poke re-asserts start with junk
  // operands mid-operation and in the DONE cycle; kill_too raises kill with start.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit poke, input bit kill_too);
    logic [31:0] exp;
    logic [31:0] got;
    int lat;
    int dc;
    logic b1;
    exp = ref_op(f, a, b);
    lat = (f[2] && b == 32'h0) ? 1 : 33;
    funct3 = f; op_a = a; op_b = b; start = 1'b1; kill = kill_too;
    tick();
    start = 1'b0; kill = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    b1 = busy;
    dc = 0;
    got = 'x;
    for (int k = 1; k <= 40 && dc == 0; k++) begin
      if (done) begin
        dc = k;
        got = result;
      end else begin
        start = poke && (k == 5);
        tick();
        start = 1'b0;
      end
    end
    start = poke;
    tick();
    start = 1'b0;
    chk({tag, " busy_t1"}, {31'h0, b1}, 32'h1);
    chk({tag, " latency"}, 32'(dc), 32'(lat));
    chk({tag, " result"}, got, exp);
    chk({tag, " busy_after"}, {31'h0, busy}, 32'h0);
    chk({tag, " held"}, result, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    bit seen;

    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) tick();
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset result", result, 32'h0);
    rst = 1'b0;
    tick();

    run_op("mul_7x6",    3'd0, 32'd7, 32'd6, 1'b0, 1'b0);
    run_op("mulh_m1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulhu_m1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mul_m1",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("divu_5_0",   3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("rem_5_0",    3'd6, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("start_busy", 3'd1, 32'h8765_4321, 32'h1234_5678, 1'b1, 1'b0);
    run_op("kill_start", 3'd4, 32'd1000, 32'hFFFF_FFFD, 1'b0, 1'b1);

    // Kill mid-calc: no done, back to idle, result untouched, then restart.
    prev = result;
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      seen |= done;
      tick();
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    repeat (3) begin
      seen |= done;
      chk("kill busy", {31'h0, busy}, 32'h0);
      tick();
    end
    chk("kill no_done", {31'h0, seen}, 32'h0);
    chk("kill result", result, prev);
    run_op("after_kill", 3'd0, 32'd3, 32'd4, 1'b0, 1'b0);

    // Reset mid-operation, with a second start ignored while busy.
    funct3 = 3'd5; op_a = 32'd999; op_b = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    funct3 = 3'd0; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    chk("pre_rst busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst result", result, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      seen |= done;
      tick();
    end
    chk("rst no_done", {31'h0, seen}, 32'h0);

    // Random operations, with a share of zero divisors and overflow-ish values.
    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
